// File: rtl/peak_meter_bank_if.sv
// Bus bundle for the multi-channel peak meter: frame strobe/data, channel
// select and clip clear going in; selected-channel meter and scan status out.
interface peak_meter_bank_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 24,
  parameter int LED_BITS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      sample_valid;
  logic [CHANNELS*WIDTH-1:0] audio_in;
  logic [SEL_W-1:0]          sel;
  logic                      clip_clear;
  logic [WIDTH-2:0]          peak_out;
  logic [LED_BITS-1:0]       led_bar;
  logic                      clip_out;
  logic                      busy;
  logic                      frame_done;
  logic                      overrun;

  modport master (
    output sample_valid, audio_in, sel, clip_clear,
    input  peak_out, led_bar, clip_out, busy, frame_done, overrun
  );

  modport slave (
    input  sample_valid, audio_in, sel, clip_clear,
    output peak_out, led_bar, clip_out, busy, frame_done, overrun
  );
endinterface

// File: rtl/peak_meter_bank.sv
// Multi-channel peak meter. A strobed frame is latched and its channels are
// scanned one per clock, updating per-channel peak-hold, timed decay and a
// sticky clip flag. One selected channel is shown as a value and a bargraph.
//
// state | meaning
// IDLE  | waiting for sample_valid; frame register holds the last frame
// SCAN  | updating channel idx each cycle, idx = 0 .. CHANNELS-1
module peak_meter_bank #(
  parameter int CHANNELS     = 8,
  parameter int WIDTH        = 24,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 10,
  parameter int LED_BITS     = 8
) (
  input logic               clk,
  input logic               rst_n,
  peak_meter_bank_if.slave  bus
);

  localparam int IDX_W  = $clog2(CHANNELS);
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam int MAG_W  = WIDTH - 1;
  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state;
  logic [CHANNELS*WIDTH-1:0] frame_q;
  logic [IDX_W-1:0]          idx;
  logic [MAG_W-1:0]          peak_q [CHANNELS];
  logic [HOLD_W-1:0]         hold_q [CHANNELS];
  logic [CHANNELS-1:0]       clip_q;
  logic                      busy_q;
  logic                      frame_done_q;
  logic                      overrun_q;

  logic [WIDTH-1:0]          x_cur;
  logic [MAG_W-1:0]          mag;
  logic [MAG_W-1:0]          peak_cur;
  logic [MAG_W-1:0]          decay;
  logic [MAG_W-1:0]          peak_dec;
  logic [MAG_W-1:0]          peak_nxt;
  logic [HOLD_W-1:0]         hold_cur;
  logic [HOLD_W-1:0]         hold_nxt;

  logic [MAG_W-1:0]          peak_out_q;
  logic [LED_BITS-1:0]       led_bar_q;
  logic                      clip_out_q;

  // Next peak/hold for the channel under the scan pointer.
  always_comb begin
    x_cur = frame_q[WIDTH-1:0];
    for (int c = 0; c < CHANNELS; c++) begin
      if (idx == IDX_W'(c)) x_cur = frame_q[c*WIDTH +: WIDTH];
    end

    // Full-scale negative has no positive twin, so it saturates.
    if (!x_cur[WIDTH-1])                mag = x_cur[MAG_W-1:0];
    else if (x_cur[MAG_W-1:0] == '0)    mag = MAG_MAX;
    else                                mag = ~x_cur[MAG_W-1:0] + MAG_W'(1);

    peak_cur = peak_q[idx];
    hold_cur = hold_q[idx];

    // Proportional decay with a 1 LSB floor so small peaks still reach zero.
    decay = peak_cur >> DECAY_SHIFT;
    if (decay == '0 && peak_cur != '0) decay = MAG_W'(1);
    peak_dec = peak_cur - decay;

    peak_nxt = peak_cur;
    hold_nxt = hold_cur;
    if (mag >= peak_cur) begin
      peak_nxt = mag;
      hold_nxt = HOLD_W'(HOLD_SAMPLES);
    end else if (hold_cur != '0) begin
      hold_nxt = hold_cur - HOLD_W'(1);
    end else begin
      peak_nxt = (peak_dec > mag) ? peak_dec : mag;
    end
  end

  // Scan sequencer: frame capture, per-channel state update and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      frame_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            frame_q <= bus.audio_in;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (bus.sample_valid) overrun_q <= 1'b1;
          peak_q[idx] <= peak_nxt;
          hold_q[idx] <= hold_nxt;
          if (idx == IDX_W'(CHANNELS - 1)) begin
            idx          <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state        <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky clip flags; a full-scale hit beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (state == SCAN && idx == IDX_W'(c) && mag == MAG_MAX)
          clip_q[c] <= 1'b1;
        else if (bus.clip_clear && bus.sel == IDX_W'(c))
          clip_q[c] <= 1'b0;
      end
    end
  end

  // Registered view of the selected channel; each segment is 6 dB apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out_q <= '0;
      clip_out_q <= 1'b0;
      led_bar_q  <= '0;
    end else begin
      peak_out_q <= peak_q[bus.sel];
      clip_out_q <= clip_q[bus.sel];
      for (int i = 0; i < LED_BITS; i++) begin
        led_bar_q[i] <= ({1'b0, peak_q[bus.sel]} >= (WIDTH'(1) << (WIDTH - 1 - LED_BITS + i)));
      end
    end
  end

  assign bus.peak_out   = peak_out_q;
  assign bus.led_bar    = led_bar_q;
  assign bus.clip_out   = clip_out_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_peak_meter_bank.sv
// Directed bench for peak_meter_bank: each accepted frame updates a reference
// model and queues the expected view of the selected channel, which is popped
// and compared once the scan has finished and the outputs have settled.
module tb_peak_meter_bank;

  localparam int CH     = 8;
  localparam int W      = 24;
  localparam int HOLD   = 4;
  localparam int DSH    = 2;
  localparam int LEDS   = 8;
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  typedef struct {
    int         peak;
    bit         clip;
    logic [7:0] led;
  } exp_t;

  logic clk;
  logic rst_n;

  peak_meter_bank_if #(.CHANNELS(CH), .WIDTH(W), .LED_BITS(LEDS)) bus ();

  peak_meter_bank #(
    .CHANNELS(CH), .WIDTH(W), .HOLD_SAMPLES(HOLD), .DECAY_SHIFT(DSH), .LED_BITS(LEDS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] fr    [CH];
  logic signed [W-1:0] fr_nx [CH];
  int   m_peak [CH];
  int   m_hold [CH];
  bit   m_clip [CH];
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] led_of(input int p);
    logic [7:0] r;
    for (int i = 0; i < LEDS; i++) r[i] = (p >= (1 << (W - 1 - LEDS + i)));
    return r;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_peak[c] = 0;
      m_hold[c] = 0;
      m_clip[c] = 1'b0;
    end
    sb.delete();
  endfunction

  // Reference behaviour for one accepted frame. clr_at = scan cycle (1..8)
  // on which clip_clear is pulsed for the selected channel, 0 for none.
  function automatic void model_frame(input int clr_at);
    int s;
    s = int'(bus.sel);
    for (int c = 0; c < CH; c++) begin
      int x, mag, d, p;
      x   = fr[c];
      mag = (x < 0) ? -x : x;
      if (mag > MAXMAG) mag = MAXMAG;
      if (mag >= m_peak[c]) begin
        m_peak[c] = mag;
        m_hold[c] = HOLD;
      end else if (m_hold[c] != 0) begin
        m_hold[c] = m_hold[c] - 1;
      end else begin
        d = m_peak[c] >> DSH;
        if (d == 0) d = 1;
        p = m_peak[c] - d;
        m_peak[c] = (p > mag) ? p : mag;
      end
      if (mag == MAXMAG) m_clip[c] = 1'b1;
      if (c == s && clr_at >= 1 && clr_at <= CH)
        m_clip[c] = (mag == MAXMAG) && (clr_at <= c + 1);
    end
  endfunction

  task automatic drive_frame(input int clr_at);
    exp_t e;
    int   s;
    for (int c = 0; c < CH; c++) bus.audio_in[c*W +: W] = fr[c];
    bus.sample_valid = 1'b1;
    model_frame(clr_at);
    s      = int'(bus.sel);
    e.peak = m_peak[s];
    e.clip = m_clip[s];
    e.led  = led_of(m_peak[s]);
    sb.push_back(e);
  endtask

  // Runs one frame through the DUT with timing checks, optional extra strobe
  // while busy, optional clip_clear pulse, and optional chaining of fr_nx on
  // the frame_done cycle. predriven: the strobe was already accepted.
  task automatic run_frame(input int extra_at, input int clr_at, input bit chain, input bit predriven);
    int   busy_cnt;
    int   done_at;
    exp_t e;
    busy_cnt = 0;
    done_at  = -1;
    if (!predriven) begin
      @(negedge clk);
      drive_frame(clr_at);
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus.sample_valid = (cyc == extra_at);
      if (cyc == extra_at) bus.audio_in = {CH{24'h800000}};
      bus.clip_clear = (cyc == clr_at);
      if (bus.busy) busy_cnt++;
      if (bus.frame_done) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.clip_clear = 1'b0;
    check("frame_done_cycle", done_at, 9);
    check("busy_cycles", busy_cnt, 8);
    if (chain) begin
      for (int c = 0; c < CH; c++) fr[c] = fr_nx[c];
      drive_frame(0);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sb_peak", bus.peak_out, e.peak);
      check("sb_clip", bus.clip_out, e.clip);
      check("sb_led", bus.led_bar, e.led);
    end
  endtask

  task automatic zero_frame();
    for (int c = 0; c < CH; c++) fr[c] = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int cur;

    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.audio_in     = '0;
    bus.sel          = '0;
    bus.clip_clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_peak_out", bus.peak_out, 0);
    check("rst_led_bar", bus.led_bar, 0);
    check("rst_clip_out", bus.clip_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero frame
    zero_frame();
    run_frame(0, 0, 0, 0);
    check("zero_overrun", bus.overrun, 0);

    // ch3 = -1000
    zero_frame();
    fr[3]   = -24'sd1000;
    bus.sel = 3'd3;
    run_frame(0, 0, 0, 0);
    check("ch3_peak", bus.peak_out, 1000);
    check("ch3_led", bus.led_bar, 8'h00);

    // Hold then decay on ch0
    bus.sel = 3'd0;
    zero_frame();
    fr[0] = 24'sd4096;
    run_frame(0, 0, 0, 0);
    check("hold_f1", bus.peak_out, 4096);
    zero_frame();
    for (int f = 0; f < 4; f++) begin
      run_frame(0, 0, 0, 0);
      check("hold_f", bus.peak_out, 4096);
    end
    run_frame(0, 0, 0, 0);
    check("decay_1", bus.peak_out, 3072);
    run_frame(0, 0, 0, 0);
    check("decay_2", bus.peak_out, 2304);
    run_frame(0, 0, 0, 0);
    check("decay_3", bus.peak_out, 1728);
    prev = 1728;
    for (int f = 0; f < 40 && prev != 0; f++) begin
      run_frame(0, 0, 0, 0);
      cur = int'(bus.peak_out);
      if (prev < 4) check("decay_lsb_step", cur, prev - 1);
      prev = cur;
    end
    check("decay_zero", bus.peak_out, 0);
    run_frame(0, 0, 0, 0);
    check("decay_floor", bus.peak_out, 0);

    // Full-scale negative on ch5
    bus.sel = 3'd5;
    zero_frame();
    fr[5] = 24'sh800000;
    run_frame(0, 0, 0, 0);
    check("fs_peak", bus.peak_out, 32'h7FFFFF);
    check("fs_led", bus.led_bar, 8'hFF);
    check("fs_clip", bus.clip_out, 1);
    zero_frame();
    run_frame(0, 0, 0, 0);
    check("clip_sticky", bus.clip_out, 1);
    bus.clip_clear = 1'b1;
    m_clip[5]      = 1'b0;
    @(negedge clk);
    bus.clip_clear = 1'b0;
    @(negedge clk);
    check("clip_cleared", bus.clip_out, 0);
    zero_frame();
    fr[5] = 24'sh800000;
    run_frame(0, 6, 0, 0);
    check("clip_set_wins", bus.clip_out, 1);

    // Overrun strobe 3 cycles in, then a strobe on the frame_done cycle
    bus.sel = 3'd2;
    zero_frame();
    fr[2] = 24'sd12345;
    for (int c = 0; c < CH; c++) fr_nx[c] = '0;
    fr_nx[2] = -24'sd20000;
    run_frame(3, 0, 1, 0);
    check("overrun_set", bus.overrun, 1);
    check("dropped_frame_peak", bus.peak_out, 12345);
    run_frame(0, 0, 0, 1);
    check("chained_frame_peak", bus.peak_out, 20000);

    // Reset in the middle of a scan
    bus.sel = 3'd0;
    @(negedge clk);
    for (int c = 0; c < CH; c++) bus.audio_in[c*W +: W] = 24'sd5000;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midscan_busy", bus.busy, 1);
    check("midscan_peak", bus.peak_out, 5000);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_peak", bus.peak_out, 0);
    check("midrst_overrun", bus.overrun, 0);
    check("midrst_clip", bus.clip_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_frame_done", bus.frame_done, 0);
    check("post_rst_peak", bus.peak_out, 0);

    // Fresh frame touching every channel after reset
    bus.sel = 3'd7;
    for (int c = 0; c < CH; c++) fr[c] = (c % 2 == 1) ? -(24'sd100 * (c + 1)) : (24'sd100 * (c + 1));
    run_frame(0, 0, 0, 0);
    check("post_rst_ch7", bus.peak_out, 800);
    bus.sel = 3'd2;
    @(negedge clk);
    check("sel_change_peak", bus.peak_out, 300);
    bus.sel = 3'd4;
    @(negedge clk);
    check("sel_change_peak4", bus.peak_out, 500);

    // Mid-range bargraph
    bus.sel = 3'd1;
    zero_frame();
    fr[1] = -24'sd65536;
    run_frame(0, 0, 0, 0);
    check("mid_led", bus.led_bar, 8'h03);
    check("mid_peak", bus.peak_out, 65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
